// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM state, timeout counter sizing,
// and a reference round-robin pick function.
package uart_tx_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int unsigned TimeoutWidthDefault = 8;
  localparam int unsigned MaxReq              = 8;

  // Stall counter width: wide enough for the limit, clamped to 8..16 bits.
  function automatic int unsigned timeout_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    if (w < TimeoutWidthDefault) w = TimeoutWidthDefault;
    if (w > 16) w = 16;
    return w;
  endfunction

  // One-hot winner: first valid bit above ptr, wrapping to the lowest valid bit.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] valid,
                                                input logic [2:0]        ptr);
    logic [MaxReq-1:0] above;
    logic [MaxReq-1:0] cand;
    above = valid & ~((MaxReq'(2) << ptr) - MaxReq'(1));
    cand  = (|above) ? above : valid;
    return cand & (~cand + MaxReq'(1));
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-lane and TX fifo write-port bundle for uart_tx_arbiter.
// master: the arbiter; slave: sources, fifo and observers.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         fifo_full;
  logic                         fifo_wr;
  logic [DATA_SIZE-1:0]         fifo_wdata;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic                         pkt_done;
  logic                         timeout_err;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_wdata, grant, busy, pkt_done, timeout_err
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_wdata, grant, busy, pkt_done, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// tx_rr_pick: combinational round-robin picker. Searches indices above ptr first,
// then falls back to an unmasked search from index 0.
module tx_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PtrW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PtrW-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PtrW-1:0]    idx,
  output logic               any
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] cand;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i > 32'(ptr));
    end
    masked = valid & mask;
    cand   = (|masked) ? masked : valid;
    onehot = cand & (~cand + NUM_REQ'(1));
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) idx = PtrW'(i);
    end
    any = |valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX fifo among NUM_REQ sources.
// Optional stall timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = timeout_width(TIMEOUT_CYCLES);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PtrW-1:0]    owner_q;
  logic [PtrW-1:0]    rr_ptr_q;
  logic               pkt_done_q;
  logic               timeout_err_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PtrW-1:0]    pick_idx;
  logic               pick_any;
  logic               busy;
  logic               beat;
  logic               stall_hit;

  tx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PtrW    (PtrW)
  ) u_pick (
    .valid  (bus.req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign busy = (state_q == ARB_BUSY);
  assign beat = bus.fifo_wr;

  assign bus.req_ready   = grant_q & {NUM_REQ{~bus.fifo_full}};
  assign bus.fifo_wr     = (|(grant_q & bus.req_valid)) & ~bus.fifo_full;
  assign bus.fifo_wdata  = busy ? bus.req_data[32'(owner_q) * DATA_SIZE +: DATA_SIZE] : '0;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy;
  assign bus.pkt_done    = pkt_done_q;
  assign bus.timeout_err = timeout_err_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [CntW-1:0] stall_cnt_q;
  logic            stall;

  // Only a missing byte counts; fifo back-pressure never ages the owner out.
  assign stall     = busy & ~bus.req_valid[owner_q];
  assign stall_hit = stall & ((stall_cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!busy || beat || stall_hit) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + CntW'(1);
    end
  end
`else
  logic [CntW-1:0] unused_timeout_cycles;
  assign unused_timeout_cycles = CntW'(TIMEOUT_CYCLES);
  assign stall_hit             = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= PtrW'(NUM_REQ - 1);
      pkt_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pkt_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            state_q <= ARB_BUSY;
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
          end
        end
        ARB_BUSY: begin
          if (beat && bus.req_last[owner_q]) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= owner_q;
            pkt_done_q <= 1'b1;
          end else if (stall_hit) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= owner_q;
            timeout_err_q <= 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_SIZE=8, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

  logic clk;
  logic reset;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_SIZE(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_SIZE      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Per-lane byte sources: {last, data}.
  logic [8:0] src_mem [4][32];
  int         src_head [4];
  int         src_tail [4];
  logic [3:0] hold;

  logic [7:0] wr_log [$];
  int         wr_cyc [$];
  logic [3:0] gnt_log [$];
  logic [3:0] prev_grant;
  int         cyc;
  int         n_done;
  int         n_tmo;
  int         tmo_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int lane, input logic last, input logic [7:0] data);
    src_mem[lane][src_tail[lane]] = {last, data};
    src_tail[lane]++;
  endtask

  task automatic flush(input int lane);
    src_head[lane] = src_tail[lane];
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++) if (src_head[i] != src_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_lanes();
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (src_head[i] != src_tail[i] && !hold[i]) begin
        v[i]         = 1'b1;
        l[i]         = src_mem[i][src_head[i]][8];
        d[i*8 +: 8]  = src_mem[i][src_head[i]][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    gnt_log.delete();
    n_done = 0;
    n_tmo  = 0;
  endtask

  always @(posedge clk) begin
    #1;
    drive_lanes();
  end

  // Values seen at the falling edge are exactly those the next rising edge acts on.
  always @(negedge clk) begin
    cyc++;
    if (bus.fifo_wr) begin
      wr_log.push_back(bus.fifo_wdata);
      wr_cyc.push_back(cyc);
    end
    if (bus.pkt_done) n_done++;
    if (bus.timeout_err) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
    if (bus.grant != prev_grant && bus.grant != 4'b0) gnt_log.push_back(bus.grant);
    prev_grant = bus.grant;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) src_head[i]++;
    end
  end

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (all_empty() && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(done), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_wr(input int n, input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (wr_log.size() >= n) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_grant(input logic [3:0] g, input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.grant == g) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp [], input int n);
    check_eq({tag, "_count"}, 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(wr_log[i]), 32'(exp[i]));
    end
  endtask

  task automatic check_grants(input string tag, input logic [3:0] exp [], input int n);
    check_eq({tag, "_gcount"}, 32'(gnt_log.size()), 32'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++) begin
      check_eq($sformatf("%s_grant%0d", tag, i), 32'(gnt_log[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] eb [];
    logic [3:0] eg [];

    for (int i = 0; i < 4; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    hold          = '0;
    prev_grant    = '0;
    cyc           = 0;
    tmo_cyc       = 0;
    reset         = 1'b1;
    bus.fifo_full = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    clear_logs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", 32'(bus.grant), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_pkt_done", 32'(bus.pkt_done), 32'h0);
    check_eq("rst_timeout_err", 32'(bus.timeout_err), 32'h0);
    check_eq("rst_fifo_wr", 32'(bus.fifo_wr), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: lanes 1 and 3, three bytes each
    clear_logs();
    push(1, 0, 8'h11); push(1, 0, 8'h12); push(1, 1, 8'h13);
    push(3, 0, 8'h31); push(3, 0, 8'h32); push(3, 1, 8'h33);
    wait_drain("t1_drain");
    eb = '{8'h11, 8'h12, 8'h13, 8'h31, 8'h32, 8'h33};
    check_bytes("t1", eb, 6);
    eg = '{4'b0010, 4'b1000};
    check_grants("t1", eg, 2);
    check_eq("t1_pkt_done", 32'(n_done), 32'd2);

    // 2: all lanes, single-byte packets; lane 0 has two
    clear_logs();
    push(0, 1, 8'h20); push(0, 1, 8'h24);
    push(1, 1, 8'h21); push(2, 1, 8'h22); push(3, 1, 8'h23);
    wait_drain("t2_drain");
    eb = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    check_bytes("t2", eb, 5);
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check_grants("t2", eg, 5);
    if (wr_cyc.size() == 5) begin
      check_eq("t2_rate_first", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
      check_eq("t2_rate_span", 32'(wr_cyc[4] - wr_cyc[0]), 32'd8);
    end else begin
      check_eq("t2_rate_samples", 32'(wr_cyc.size()), 32'd5);
    end

    // 3: fifo_full for 5 cycles after the first byte of lane 2
    clear_logs();
    push(2, 0, 8'hA1); push(2, 0, 8'hA2); push(2, 1, 8'hA3);
    wait_wr(1, "t3_first");
    #1 bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t3_stall_wr", 32'(bus.fifo_wr), 32'h0);
      check_eq("t3_stall_grant", 32'(bus.grant), 32'h4);
      check_eq("t3_stall_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk);
    #1 bus.fifo_full = 1'b0;
    wait_drain("t3_drain");
    eb = '{8'hA1, 8'hA2, 8'hA3};
    check_bytes("t3", eb, 3);
    check_eq("t3_pkt_done", 32'(n_done), 32'd1);

    // 4: lane 1 owns, lane 3 waits while lane 1 goes quiet for 10 cycles
    clear_logs();
    push(1, 0, 8'h41); push(1, 0, 8'h42); push(1, 0, 8'h43); push(1, 1, 8'h44);
    wait_grant(4'b0010, "t4_grant1");
    push(3, 1, 8'h71);
    wait_wr(1, "t4_first");
    hold[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("t4_hold_grant", 32'(bus.grant), 32'h2);
      check_eq("t4_hold_wr", 32'(bus.fifo_wr), 32'h0);
    end
    @(posedge clk);
    hold[1] = 1'b0;
    wait_drain("t4_drain");
    eb = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h71};
    check_bytes("t4", eb, 5);
    eg = '{4'b0010, 4'b1000};
    check_grants("t4", eg, 2);

    // 5: reset during byte 2 of a 4-byte packet
    clear_logs();
    push(0, 0, 8'h51); push(0, 0, 8'h52); push(0, 0, 8'h53); push(0, 1, 8'h54);
    wait_wr(1, "t5_first");
    #1 reset = 1'b1;
    #1;
    check_eq("t5_rst_grant", 32'(bus.grant), 32'h0);
    check_eq("t5_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("t5_rst_wr", 32'(bus.fifo_wr), 32'h0);
    check_eq("t5_partial", 32'(wr_log.size()), 32'd1);
    flush(0);
    clear_logs();
    push(0, 1, 8'h61); push(2, 1, 8'h62);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_drain("t5_drain");
    eb = '{8'h61, 8'h62};
    check_bytes("t5", eb, 2);
    eg = '{4'b0001, 4'b0100};
    check_grants("t5", eg, 2);

    // 6: owner stalls with no data
    clear_logs();
    push(1, 0, 8'h81); push(1, 0, 8'h82); push(1, 1, 8'h83);
    wait_grant(4'b0010, "t6_grant1");
    push(2, 1, 8'h91);
    wait_wr(1, "t6_first");
    hold[1] = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 0; k < 40 && n_tmo == 0; k++) @(posedge clk);
    check_eq("t6_tmo_count", 32'(n_tmo), 32'd1);
    check_eq("t6_tmo_latency", 32'(tmo_cyc - wr_cyc[0]), 32'd17);
    check_eq("t6_no_pkt_done", 32'(n_done), 32'd0);
    flush(1);
    hold[1] = 1'b0;
    wait_drain("t6_drain");
    eb = '{8'h81, 8'h91};
    check_bytes("t6", eb, 2);
    eg = '{4'b0010, 4'b0100};
    check_grants("t6", eg, 2);
`else
    repeat (40) @(negedge clk);
    check_eq("t6_held_grant", 32'(bus.grant), 32'h2);
    check_eq("t6_held_busy", 32'(bus.busy), 32'h1);
    check_eq("t6_no_tmo", 32'(n_tmo), 32'd0);
    check_eq("t6_held_count", 32'(wr_log.size()), 32'd1);
    @(posedge clk);
    hold[1] = 1'b0;
    wait_drain("t6_drain");
    eb = '{8'h81, 8'h82, 8'h83, 8'h91};
    check_bytes("t6", eb, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
